// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the 8-bit single-bus CPU sequencer: widths, opcodes,
// control-bit positions, microwords, step names and sequencer states.
package micro_sequencer_pkg;

  localparam int CTRL_W = 16;
  localparam int STEP_W = 3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int B_HLT        = 15;
  localparam int B_PC_INC     = 14;
  localparam int B_PC_LOAD    = 13;
  localparam int B_PC_EN      = 12;
  localparam int B_MAR_LOAD   = 11;
  localparam int B_MEM_ST     = 10;
  localparam int B_MEM_EN     = 9;
  localparam int B_IR_LOAD    = 8;
  localparam int B_IR_EN      = 7;
  localparam int B_A_LOAD     = 6;
  localparam int B_A_EN       = 5;
  localparam int B_B_LOAD     = 4;
  localparam int B_ADDER_SUB  = 3;
  localparam int B_ADDER_EN   = 2;
  localparam int B_FLAGS_LOAD = 1;
  localparam int B_OUT_LOAD   = 0;

  localparam logic [CTRL_W-1:0] ONE = CTRL_W'(1);

  // Microwords assembled from bit positions so the bit map lives in one place.
  localparam logic [CTRL_W-1:0] UW_FETCH_ADDR = (ONE << B_PC_EN) | (ONE << B_MAR_LOAD);
  localparam logic [CTRL_W-1:0] UW_FETCH_INST = (ONE << B_MEM_EN) | (ONE << B_IR_LOAD) | (ONE << B_PC_INC);
  localparam logic [CTRL_W-1:0] UW_IR_TO_MAR  = (ONE << B_IR_EN) | (ONE << B_MAR_LOAD);
  localparam logic [CTRL_W-1:0] UW_MEM_TO_A   = (ONE << B_MEM_EN) | (ONE << B_A_LOAD);
  localparam logic [CTRL_W-1:0] UW_MEM_TO_B   = (ONE << B_MEM_EN) | (ONE << B_B_LOAD);
  localparam logic [CTRL_W-1:0] UW_SUM_TO_A   = (ONE << B_ADDER_EN) | (ONE << B_A_LOAD) | (ONE << B_FLAGS_LOAD);
  localparam logic [CTRL_W-1:0] UW_DIFF_TO_A  = UW_SUM_TO_A | (ONE << B_ADDER_SUB);
  localparam logic [CTRL_W-1:0] UW_A_TO_MEM   = (ONE << B_A_EN) | (ONE << B_MEM_ST);
  localparam logic [CTRL_W-1:0] UW_IR_TO_A    = (ONE << B_IR_EN) | (ONE << B_A_LOAD);
  localparam logic [CTRL_W-1:0] UW_IR_TO_PC   = (ONE << B_IR_EN) | (ONE << B_PC_LOAD);
  localparam logic [CTRL_W-1:0] UW_A_TO_OUT   = (ONE << B_A_EN) | (ONE << B_OUT_LOAD);
  localparam logic [CTRL_W-1:0] UW_HALT       = ONE << B_HLT;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/micro_sequencer_microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word and a flag
// marking the final micro-step of the instruction.
module microcode_rom
  import micro_sequencer_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] ctrl,
  output logic              last
);

  always_comb begin
    ctrl = '0;
    last = 1'b0;
    case (step)
      T0: ctrl = UW_FETCH_ADDR;
      T1: ctrl = UW_FETCH_INST;
      T2: begin
        last = 1'b1;
        case (opcode)
          OP_NOP: ctrl = '0;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl = UW_IR_TO_MAR;
            last = 1'b0;
          end
          OP_LDI: ctrl = UW_IR_TO_A;
          OP_JMP: ctrl = UW_IR_TO_PC;
          // Conditional jumps look at the flags live, so ctrl follows them within T2.
          OP_JC:  ctrl = flag_c ? UW_IR_TO_PC : '0;
          OP_JZ:  ctrl = flag_z ? UW_IR_TO_PC : '0;
          OP_OUT: ctrl = UW_A_TO_OUT;
          OP_HLT: ctrl = UW_HALT;
          default: ctrl = '0;
        endcase
      end
      T3: begin
        last = 1'b1;
        case (opcode)
          OP_LDA: ctrl = UW_MEM_TO_A;
          OP_ADD, OP_SUB: begin
            ctrl = UW_MEM_TO_B;
            last = 1'b0;
          end
          OP_STA: ctrl = UW_A_TO_MEM;
          default: ctrl = '0;
        endcase
      end
      T4: begin
        last = 1'b1;
        case (opcode)
          OP_ADD:  ctrl = UW_SUM_TO_A;
          OP_SUB:  ctrl = UW_DIFF_TO_A;
          default: ctrl = '0;
        endcase
      end
      default: begin
        ctrl = '0;
        last = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Instruction sequencer FSM and micro-step counter; control words come from
// microcode_rom. run pauses at instruction boundaries; HALT is terminal.
module micro_sequencer
  import micro_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_btn,
  input  logic [3:0]        opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  input  logic              run,
  input  logic              step_req,
  output logic [CTRL_W-1:0] ctrl,
  output logic [STEP_W-1:0] step,
  output logic              instr_done,
  output logic              halted,
  output seq_state_t        state_dbg
);

  // Start control: in IDLE, run or a one-cycle step_req starts an instruction at
  // the next posedge; step_req seen in EXEC or HALT is dropped, never queued.
  seq_state_t        state_q, state_nx;
  logic [STEP_W-1:0] step_q, step_nx;
  logic [CTRL_W-1:0] rom_ctrl;
  logic              rom_last;

  microcode_rom u_rom (
    .opcode (opcode),
    .step   (step_q),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (rom_ctrl),
    .last   (rom_last)
  );

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= IDLE;
      step_q  <= T0;
    end else begin
      state_q <= state_nx;
      step_q  <= step_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    step_nx  = step_q;
    case (state_q)
      IDLE: begin
        step_nx = T0;
        if (run || step_req) state_nx = EXEC;
      end
      EXEC: begin
        if (step_q > T4) begin
          step_nx = T0;
        end else if (rom_last) begin
          step_nx = T0;
          if (rom_ctrl[B_HLT]) state_nx = HALT;
          else if (!run)       state_nx = IDLE;
        end else begin
          step_nx = step_q + STEP_W'(1);
        end
      end
      HALT: step_nx = T0;
      default: begin
        state_nx = IDLE;
        step_nx  = T0;
      end
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      EXEC:    ctrl = rom_ctrl;
      HALT:    ctrl = UW_HALT;
      default: ctrl = '0;
    endcase
  end

  assign instr_done = (state_q == EXEC) && rom_last;
  assign halted     = (state_q == HALT);
  assign step       = step_q;
  assign state_dbg  = state_q;

endmodule
